// File: rtl/fft_win_wr_ctrl.sv
// fft_win_wr_ctrl: captures a frame-aligned window of FFT modulus bins into RAM and tracks the peak bin.
module fft_win_wr_ctrl #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 12,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  win_start,
  input  logic [ADDR_W:0]   win_len,
  input  logic [DATA_W-1:0] data_modulus,
  input  logic              data_valid,
  input  logic              data_last,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              busy,
  output logic              wr_done,
  output logic              done_pulse,
  output logic              fft_shutdown,
  output logic              frame_err,
  output logic              cfg_err,
  output logic [DATA_W-1:0] peak_val,
  output logic [ADDR_W-1:0] peak_addr
);
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;
  state_t            state_q;
  logic [IDX_W-1:0]  bin_q, ws_q;
  logic [ADDR_W:0]   wl_q, wcnt_q;
  logic [IDX_W:0]    bin_x, lo, hi;
  logic              in_win, is_end, cfg_ok, take, capt, wr, fin;
  // One extra bit keeps win_start+win_len from wrapping past the frame end
  assign bin_x  = {1'b0, bin_q};
  assign lo     = {1'b0, ws_q};
  assign hi     = lo + (IDX_W+1)'(wl_q);
  assign in_win = bin_x >= lo && bin_x < hi;
  assign is_end = bin_x == hi - 1'b1;
  assign cfg_ok = win_len != '0 && win_len <= (ADDR_W+1)'(DEPTH);
  assign take   = start && (state_q == IDLE || state_q == DONE);
  assign capt   = data_valid && (state_q == CAPTURE || (state_q == ARM && bin_q == '0));
  assign wr     = capt && in_win;
  assign fin    = capt && (is_end || data_last);
  assign fft_shutdown = wr_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      ws_q       <= '0;
      wl_q       <= '0;
      wcnt_q     <= '0;
      wr_data    <= '0;
      wr_addr    <= '0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      wr_done    <= 1'b0;
      done_pulse <= 1'b0;
      frame_err  <= 1'b0;
      cfg_err    <= 1'b0;
      peak_val   <= '0;
      peak_addr  <= '0;
    end else begin
      if (data_valid) bin_q <= data_last ? '0 : bin_q + 1'b1;
      wr_en <= wr;
      if (wr) begin
        wr_addr <= ADDR_W'(bin_x - lo);
        wr_data <= data_modulus;
        wcnt_q  <= wcnt_q + 1'b1;
        if (wcnt_q == '0 || data_modulus > peak_val) begin
          peak_val  <= data_modulus;
          peak_addr <= ADDR_W'(bin_x - lo);
        end
      end
      // DONE flags rise one cycle after entry, i.e. just after the final write
      wr_done    <= state_q == DONE && !start;
      done_pulse <= state_q == DONE && !start && !wr_done;
      if (take) begin
        if (cfg_ok) begin
          ws_q      <= win_start;
          wl_q      <= win_len;
          wcnt_q    <= '0;
          frame_err <= 1'b0;
          cfg_err   <= 1'b0;
          peak_val  <= '0;
          peak_addr <= '0;
          busy      <= 1'b1;
          state_q   <= ARM;
        end else begin
          cfg_err <= 1'b1;
          state_q <= IDLE;
        end
      end else if (fin) begin
        frame_err <= !is_end;
        busy      <= 1'b0;
        state_q   <= DONE;
      end else if (capt) begin
        state_q <= CAPTURE;
      end
    end
  end
endmodule
